// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one uart_tx among N_REQ byte streams.
// Define UART_ARB_HDR_EN to prefix each packet with header byte 8'h80 | grant_id.
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ID_W      = 2,
    parameter int MAX_BURST = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_stb,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_active
);

    localparam int CW = $clog2(MAX_BURST) + 1;

`ifdef UART_ARB_HDR_EN
    typedef enum logic [1:0] {IDLE, HDR, ACCEPT, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCEPT, GAP} state_t;
`endif

    state_t          state_q, state_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic            active_q, active_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
    logic            last_q, last_d;
    logic            tx_stb_q, tx_stb_d;
    logic [7:0]      tx_data_q, tx_data_d;

    logic            found;
    logic [ID_W-1:0] winner;
    logic            g_valid;
    logic            g_last;
    logic [7:0]      g_data;
    logic [ID_W-1:0] next_ptr;

    // First valid requester starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        if (int'(grant_id_q) >= N_REQ - 1) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_id_q + ID_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        active_d   = active_q;
        rr_ptr_d   = rr_ptr_q;
        byte_cnt_d = byte_cnt_q;
        last_d     = last_q;
        tx_stb_d   = 1'b0;
        tx_data_d  = tx_data_q;
        req_ready  = '0;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_id_d = winner;
                    active_d   = 1'b1;
                    byte_cnt_d = '0;
`ifdef UART_ARB_HDR_EN
                    state_d    = HDR;
`else
                    state_d    = ACCEPT;
`endif
                end
            end
`ifdef UART_ARB_HDR_EN
            HDR: begin
                if (!tx_busy) begin
                    tx_data_d = 8'h80 | 8'(grant_id_q);
                    tx_stb_d  = 1'b1;
                    last_d    = 1'b0;
                    state_d   = GAP;
                end
            end
`endif
            ACCEPT: begin
                for (int i = 0; i < N_REQ; i++) begin
                    req_ready[i] = (grant_id_q == ID_W'(i)) && !tx_busy && !rst;
                end
                if (g_valid && !tx_busy) begin
                    tx_data_d  = g_data;
                    tx_stb_d   = 1'b1;
                    byte_cnt_d = byte_cnt_q + CW'(1);
                    last_d     = g_last | (byte_cnt_q == CW'(MAX_BURST - 1));
                    state_d    = GAP;
                end
            end
            GAP: begin
                // Busy from uart_tx lags stb by one cycle; this state covers it.
                if (last_q) begin
                    active_d = 1'b0;
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end else begin
                    state_d  = ACCEPT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            active_q   <= 1'b0;
            rr_ptr_q   <= '0;
            byte_cnt_q <= '0;
            last_q     <= 1'b0;
            tx_stb_q   <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            active_q   <= active_d;
            rr_ptr_q   <= rr_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            last_q     <= last_d;
            tx_stb_q   <= tx_stb_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_stb       = tx_stb_q;
    assign tx_data      = tx_data_q;
    assign grant_id     = grant_id_q;
    assign grant_active = active_q;

endmodule
